// File: rtl/pe_acc_stage.sv
// Tile accumulator behind the PE adder tree: sums unsigned partial sums with
// saturation and hands the tile result to the result path over valid/ready.
module pe_acc_stage #(
    parameter int IN_WIDTH  = 30,
    parameter int ACC_WIDTH = 36,
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_WIDTH-1:0]  in_data,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [ACC_WIDTH-1:0] out_data,
    output logic [CNT_WIDTH-1:0] out_count,
    output logic                 out_sat
);

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_e;

    // Returns {overflow, clamped}; the carry bit doubles as the saturation flag.
    function automatic logic [ACC_WIDTH:0] sat_clamp(input logic [ACC_WIDTH:0] wide);
        sat_clamp = wide[ACC_WIDTH] ? {1'b1, {ACC_WIDTH{1'b1}}} : wide;
    endfunction

    state_e               state_q, state_d;
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 sat_sticky_q, sat_sticky_d;
    logic                 out_valid_q, out_valid_d;
    logic [ACC_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_WIDTH-1:0] out_count_q, out_count_d;
    logic                 out_sat_q, out_sat_d;

    logic                 accept;
    logic [ACC_WIDTH:0]   sum_wide;
    logic [ACC_WIDTH:0]   sum_clamped;
    logic                 sat_now;
    logic [CNT_WIDTH-1:0] cnt_inc;

    // In HOLD the result is always valid, so both arms match !(out_valid && !out_ready).
    always_comb begin
        if (state_q == HOLD) begin
            in_ready = out_ready;
        end else begin
            in_ready = !(out_valid_q && !out_ready);
        end
    end

    assign accept      = in_valid && in_ready;
    assign sum_wide    = {1'b0, acc_q} + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, in_data};
    assign sum_clamped = sat_clamp(sum_wide);
    assign sat_now     = sum_clamped[ACC_WIDTH];
    assign cnt_inc     = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q
                                                      : cnt_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACC:     if (out_valid_q && !out_ready) state_d = HOLD;
            HOLD:    if (out_ready)                 state_d = ACC;
            default: state_d = ACC;
        endcase
    end

    // in_data only reaches state through accept, so X on an idle bus stays out of acc.
    always_comb begin
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        sat_sticky_d = sat_sticky_q;
        out_valid_d  = out_valid_q;
        out_data_d   = out_data_q;
        out_count_d  = out_count_q;
        out_sat_d    = out_sat_q;

        if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end

        if (accept) begin
            if (in_last) begin
                out_valid_d  = 1'b1;
                out_data_d   = sum_clamped[ACC_WIDTH-1:0];
                out_count_d  = cnt_inc;
                out_sat_d    = sat_sticky_q | sat_now;
                acc_d        = '0;
                cnt_d        = '0;
                sat_sticky_d = 1'b0;
            end else begin
                acc_d        = sum_clamped[ACC_WIDTH-1:0];
                cnt_d        = cnt_inc;
                sat_sticky_d = sat_sticky_q | sat_now;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ACC;
            acc_q        <= '0;
            cnt_q        <= '0;
            sat_sticky_q <= 1'b0;
            out_valid_q  <= 1'b0;
            out_data_q   <= '0;
            out_count_q  <= '0;
            out_sat_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            sat_sticky_q <= sat_sticky_d;
            out_valid_q  <= out_valid_d;
            out_data_q   <= out_data_d;
            out_count_q  <= out_count_d;
            out_sat_q    <= out_sat_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_count = out_count_q;
    assign out_sat   = out_sat_q;

endmodule

// File: tb/tb_pe_acc_stage.sv
// Scoreboard bench for pe_acc_stage: directed tiles push expected results,
// a negedge monitor pops and compares every consumed output.
module tb_pe_acc_stage;

    localparam int IN_WIDTH  = 30;
    localparam int ACC_WIDTH = 36;
    localparam int CNT_WIDTH = 8;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 in_valid;
    logic                 in_ready;
    logic [IN_WIDTH-1:0]  in_data;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [ACC_WIDTH-1:0] out_data;
    logic [CNT_WIDTH-1:0] out_count;
    logic                 out_sat;

    typedef struct packed {
        logic                 sat;
        logic [CNT_WIDTH-1:0] count;
        logic [ACC_WIDTH-1:0] data;
    } result_t;

    result_t exp_q[$];
    int      n_pass  = 0;
    int      n_total = 0;

    pe_acc_stage #(
        .IN_WIDTH (IN_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_last  (in_last),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
        .out_count(out_count),
        .out_sat  (out_sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Presents one beat and waits (bounded) for it to be accepted.
    task automatic send(input logic [IN_WIDTH-1:0] d, input logic last,
                        input logic [ACC_WIDTH-1:0] exp_d, input logic [CNT_WIDTH-1:0] exp_c,
                        input logic exp_s);
        int budget;
        result_t r;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        budget   = 0;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("accept_timeout", 64'(in_ready), 64'd1);
        end else if (last) begin
            r.sat   = exp_s;
            r.count = exp_c;
            r.data  = exp_d;
            exp_q.push_back(r);
        end
        tick();
        in_valid = 1'b0;
        in_data  = 'x;
        in_last  = 1'b0;
    endtask

    // Monitor: every consumed result must match the head of the scoreboard.
    always @(negedge clk) begin
        result_t e;
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 64'(out_data), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("out_data",  64'(out_data),  64'(e.data));
                check("out_count", 64'(out_count), 64'(e.count));
                check("out_sat",   64'(out_sat),   64'(e.sat));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;

        #3;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data",  64'(out_data),  64'd0);
        check("rst_out_count", 64'(out_count), 64'd0);
        check("rst_out_sat",   64'(out_sat),   64'd0);
        check("rst_in_ready",  64'(in_ready),  64'd1);
        tick();
        tick();
        rst = 1'b0;
        tick();

        // Four-beat tile, result valid one cycle after the last accept, then drops.
        send(30'd100, 1'b0, '0, '0, 1'b0);
        send(30'd200, 1'b0, '0, '0, 1'b0);
        send(30'd300, 1'b0, '0, '0, 1'b0);
        send(30'd400, 1'b1, 36'd1000, 8'd4, 1'b0);
        check("t1_valid_after_last", 64'(out_valid), 64'd1);
        tick();
        check("t1_valid_drops", 64'(out_valid), 64'd0);

        // Single-beat tile at the full input range.
        send(30'h3FFF_FFFF, 1'b1, 36'd1073741823, 8'd1, 1'b0);
        tick();

        // 80 beats of max input saturate the accumulator.
        for (int i = 0; i < 79; i++) send(30'h3FFF_FFFF, 1'b0, '0, '0, 1'b0);
        send(30'h3FFF_FFFF, 1'b1, 36'd68719476735, 8'd80, 1'b1);
        send(30'd5, 1'b1, 36'd5, 8'd1, 1'b0);
        tick();

        // Backpressure: result 15 held for 5 cycles, the next beat must wait.
        out_ready = 1'b0;
        send(30'd7, 1'b0, '0, '0, 1'b0);
        send(30'd8, 1'b1, 36'd15, 8'd2, 1'b0);
        in_valid = 1'b1;
        in_data  = 30'd1;
        in_last  = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready",  64'(in_ready),  64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
            check("hold_out_data",  64'(out_data),  64'd15);
            check("hold_out_count", 64'(out_count), 64'd2);
            tick();
        end
        out_ready = 1'b1;
        send(30'd1, 1'b0, '0, '0, 1'b0);
        send(30'd2, 1'b1, 36'd3, 8'd2, 1'b0);
        tick();
        tick();

        // Back-to-back single-beat tiles with in_valid held.
        send(30'd9, 1'b1, 36'd9, 8'd1, 1'b0);
        check("b2b_valid_9", 64'(out_valid), 64'd1);
        send(30'd10, 1'b1, 36'd10, 8'd1, 1'b0);
        check("b2b_valid_10", 64'(out_valid), 64'd1);
        check("b2b_data_10",  64'(out_data),  64'd10);
        send(30'd11, 1'b1, 36'd11, 8'd1, 1'b0);
        check("b2b_valid_11", 64'(out_valid), 64'd1);
        check("b2b_data_11",  64'(out_data),  64'd11);
        tick();
        check("b2b_valid_drops", 64'(out_valid), 64'd0);

        // Asynchronous reset mid-tile discards the partial sum.
        send(30'd50, 1'b0, '0, '0, 1'b0);
        send(30'd60, 1'b0, '0, '0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_out_data",  64'(out_data),  64'd0);
        check("midrst_out_count", 64'(out_count), 64'd0);
        check("midrst_out_sat",   64'(out_sat),   64'd0);
        check("midrst_in_ready",  64'(in_ready),  64'd1);
        tick();
        rst = 1'b0;
        tick();
        send(30'd1, 1'b1, 36'd1, 8'd1, 1'b0);

        repeat (3) tick();
        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
